fetch_frontend: RTL and testbench
=================================

FETCH_FRONTEND -- requirements
Module: fetch_frontend

Interface
REQ-001 Parameter: MEM_LAT, 1, fixed instruction-memory read latency in cycles; legal values 1..4.
REQ-002 Parameter: DEPTH, 4, instruction buffer entries; power of two, at least 2.
REQ-003 Parameter: RESET_PC, 32'h0, fetch address after reset.
REQ-004 Port: clk  input  1  rising-edge clock; the block uses one clock; reset is synchronous and active-high.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: halt  input  1  inhibits new fetch issue while high.
REQ-007 Port: flush  input  1  discards buffered and in-flight fetches and loads redirect_pc.
REQ-008 Port: redirect_pc  input  32  new fetch address, sampled when flush=1.
REQ-009 Port: mem_req  output  1  read request issued this cycle.
REQ-010 Port: mem_addr  output  32  instruction read address, valid when mem_req=1.
REQ-011 Port: mem_rdata  input  32  read data for the request issued MEM_LAT cycles earlier.
REQ-012 Port: out_valid  output  1  head buffer entry is valid.
REQ-013 Port: out_ready  input  1  decode accepts the head entry (the inverse of decode stall).
REQ-014 Port: out_instr  output  32  head instruction word.
REQ-015 Port: out_pc  output  32  address of the head instruction.

Function
REQ-016 State: fetch PC register, a MEM_LAT-deep in-flight pipeline (valid bit and pc per slot), a DEPTH-entry circular buffer (instr and pc) with read and write pointers, and an occupancy count of width $clog2(DEPTH)+1.
REQ-017 mem_addr shall equal the fetch PC register combinationally; mem_req = !rst && !halt && !flush && (occupancy + inflight < DEPTH), where both counts are registered values from the start of the cycle.
REQ-018 A pop in the current cycle shall not free a credit until the next cycle.
REQ-019 On issue, the fetch PC shall advance by 4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h0.
REQ-020 A request issued in cycle t shall sample mem_rdata in cycle t+MEM_LAT, write the buffer at the end of that cycle, and appear on out_valid in cycle t+MEM_LAT+1.
REQ-021 The head entry shall be popped when out_valid && out_ready; out_instr and out_pc shall hold steady while out_valid && !out_ready.
REQ-022 A return and a pop in the same cycle shall both take effect, leaving occupancy unchanged.
REQ-023 Because every issue is credit-checked, the buffer shall never overflow.
REQ-024 Delivery shall be in program order, with no duplicate and no skipped instruction between flushes.
REQ-025 On flush: fetch PC <= redirect_pc; all in-flight valid bits cleared; buffer emptied (pointers and count to 0); no issue and no pop that cycle; flush takes priority over a simultaneous return, pop, or halt.
REQ-026 The first issue after a flush in cycle r shall occur in cycle r+1 (if not halted); out_valid for it shall occur in r+2+MEM_LAT.
REQ-027 Throughput: with out_ready=1, halt=0, and DEPTH >= MEM_LAT+2, one instruction shall be delivered per cycle in steady state.
REQ-028 Throughput: a smaller DEPTH shall throttle delivery but remain correct.
REQ-029 Halt shall block issue only; in-flight requests complete and the buffer keeps draining into decode.
REQ-030 out_valid shall be 0 whenever occupancy is 0; there is no combinational bypass from mem_rdata to the outputs.

Reset
REQ-031 While rst=1: fetch PC <= RESET_PC, in-flight valids cleared, buffer empty, mem_req=0, out_valid=0.
REQ-032 out_instr and out_pc shall read 32'h0 after reset until the first write.
REQ-033 Reset asserted mid-operation shall drop every outstanding request; data returning after reset shall not be written.
REQ-034 The first issue after reset shall be at RESET_PC, in the first cycle with rst=0.

Verification
REQ-035 Reset release, MEM_LAT=1, DEPTH=4, out_ready=1 -> mem_addr 0,4,8,... in consecutive cycles; out_pc 0 first valid in cycle 2 after release, then one per cycle.
REQ-036 Backpressure, out_ready=0 from cycle 0 -> exactly DEPTH issues (PCs 0..12), mem_req low thereafter, and out_pc holds 0; on out_ready=1, PCs 0..12 drain in order and the first new issue is 16.
REQ-037 Flush with redirect_pc=32'h100 while 2 requests are in flight and the buffer is full -> no stale words delivered; next issue at 0x100; out_pc=0x100 valid in r+2+MEM_LAT.
REQ-038 Flush coinciding with a pop and a return -> occupancy 0 next cycle and neither word is ever delivered.
REQ-039 PC wrap: redirect to 32'hFFFFFFF8 -> issues FFFFFFF8, FFFFFFFC, 00000000; out_pc matches in order.
REQ-040 MEM_LAT=3, DEPTH=4 with out_ready=1 -> delivery throttled to 4 instructions per 5 cycles, with no loss; halt for 5 cycles -> buffer drains to empty, then resumes at the correct next PC.

Source files
------------

// File: rtl/fetch_frontend.sv
// rtl/fetch_frontend.sv - instruction fetch front end: credit-checked issue, fixed-latency return, in-order buffer
module fetch_frontend #(
  parameter int          MEM_LAT  = 1,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]        pc_q;
  logic [MEM_LAT-1:0] fl_valid;
  logic [31:0]        fl_pc [MEM_LAT];
  logic [31:0]        buf_instr [DEPTH];
  logic [31:0]        buf_pc [DEPTH];
  logic [PW-1:0]      rptr;
  logic [PW-1:0]      wptr;
  logic [CW-1:0]      count;
  logic [31:0]        used;
  logic               ret;
  logic               pop;

  // Credits consumed = buffered entries plus requests still in the memory pipe.
  always_comb begin
    used = 32'(count);
    for (int i = 0; i < MEM_LAT; i++) begin
      used = used + 32'(fl_valid[i]);
    end
  end

  assign mem_req   = !rst && !halt && !flush && (used < 32'(DEPTH));
  assign mem_addr  = pc_q;
  assign ret       = fl_valid[MEM_LAT-1];
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !flush;
  assign out_instr = buf_instr[rptr];
  assign out_pc    = buf_pc[rptr];

  always_ff @(posedge clk) begin
    fl_pc[0] <= pc_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      fl_pc[i] <= fl_pc[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      fl_valid <= '0;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= 32'h0;
        buf_pc[i]    <= 32'h0;
      end
    end else if (flush) begin
      pc_q     <= redirect_pc;
      fl_valid <= '0;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
    end else begin
      if (mem_req) begin
        pc_q <= pc_q + 32'd4;
      end
      fl_valid[0] <= mem_req;
      for (int i = 1; i < MEM_LAT; i++) begin
        fl_valid[i] <= fl_valid[i-1];
      end
      if (ret) begin
        buf_instr[wptr] <= mem_rdata;
        buf_pc[wptr]    <= fl_pc[MEM_LAT-1];
        wptr            <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({ret, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_frontend.sv
// tb/tb_fetch_frontend.sv - randomized check of two fetch_frontend configurations against a queue model
module tb_fetch_frontend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, halt = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] redirect_pc = 32'h0;
  logic        nx_rst, nx_halt, nx_flush, nx_ready;
  logic [31:0] nx_redirect;

  logic        mem_req   [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_rdata [2];
  logic        out_valid [2];
  logic [31:0] out_instr [2];
  logic [31:0] out_pc    [2];

  fetch_frontend #(.MEM_LAT(1), .DEPTH(4), .RESET_PC(32'h0)) u0 (
    .clk(clk), .rst(rst), .halt(halt), .flush(flush), .redirect_pc(redirect_pc),
    .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_instr(out_instr[0]), .out_pc(out_pc[0])
  );

  fetch_frontend #(.MEM_LAT(3), .DEPTH(4), .RESET_PC(32'h0)) u1 (
    .clk(clk), .rst(rst), .halt(halt), .flush(flush), .redirect_pc(redirect_pc),
    .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_instr(out_instr[1]), .out_pc(out_pc[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: FIFO of delivered-but-unpopped PCs and FIFO of outstanding requests.
  logic [31:0] q_buf  [2][$];
  logic [31:0] q_fpc  [2][$];
  int          q_fret [2][$];
  logic [31:0] epc    [2];
  logic        hv     [2][4];
  logic [31:0] ha     [2][4];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_5A17;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic model_cycle(input int k);
    int   occ = q_buf[k].size();
    int   inf = q_fpc[k].size();
    logic er  = !rst && !halt && !flush && (occ + inf < 4);
    logic rt  = (inf > 0) && (q_fret[k][0] == cyc);
    chk($sformatf("u%0d.mem_req@%0d", k, cyc), 32'(mem_req[k]), 32'(er));
    if (er) chk($sformatf("u%0d.mem_addr@%0d", k, cyc), mem_addr[k], epc[k]);
    chk($sformatf("u%0d.out_valid@%0d", k, cyc), 32'(out_valid[k]), 32'(occ > 0));
    if (occ > 0) begin
      chk($sformatf("u%0d.out_pc@%0d", k, cyc), out_pc[k], q_buf[k][0]);
      chk($sformatf("u%0d.out_instr@%0d", k, cyc), out_instr[k], memf(q_buf[k][0]));
    end
    if (rst || flush) begin
      q_buf[k].delete();
      q_fpc[k].delete();
      q_fret[k].delete();
      epc[k] = rst ? 32'h0 : redirect_pc;
    end else begin
      if (occ > 0 && out_ready) void'(q_buf[k].pop_front());
      if (rt) begin
        q_buf[k].push_back(q_fpc[k].pop_front());
        void'(q_fret[k].pop_front());
      end
      if (er) begin
        q_fpc[k].push_back(epc[k]);
        q_fret[k].push_back(cyc + lat(k));
        epc[k] = epc[k] + 32'd4;
      end
    end
    for (int i = 3; i > 0; i--) begin
      hv[k][i] = hv[k][i-1];
      ha[k][i] = ha[k][i-1];
    end
    hv[k][0] = mem_req[k];
    ha[k][0] = mem_addr[k];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst         = nx_rst;
    halt        = nx_halt;
    flush       = nx_flush;
    out_ready   = nx_ready;
    redirect_pc = nx_redirect;
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = hv[k][lat(k)-1] ? memf(ha[k][lat(k)-1]) : $urandom;
    end
    @(negedge clk);
    model_cycle(0);
    model_cycle(1);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      epc[k] = 32'h0;
      mem_rdata[k] = 32'h0;
      for (int i = 0; i < 4; i++) begin
        hv[k][i] = 1'b0;
        ha[k][i] = 32'h0;
      end
    end
    nx_rst = 1'b1; nx_halt = 1'b0; nx_flush = 1'b0; nx_ready = 1'b1; nx_redirect = 32'h0;
    run(3);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.reset_instr", k), out_instr[k], 32'h0);
      chk($sformatf("u%0d.reset_pc", k), out_pc[k], 32'h0);
    end

    nx_rst = 1'b0;
    run(30);

    nx_rst = 1'b1; run(2);
    nx_rst = 1'b0; nx_ready = 1'b0; run(15);
    nx_ready = 1'b1; run(10);

    nx_ready = 1'b0; run(3);
    nx_flush = 1'b1; nx_redirect = 32'h100; run(1);
    nx_flush = 1'b0; nx_ready = 1'b1; run(10);

    nx_flush = 1'b1; nx_redirect = 32'h200; run(1);
    nx_flush = 1'b0; run(10);

    nx_flush = 1'b1; nx_redirect = 32'hFFFF_FFF8; run(1);
    nx_flush = 1'b0; run(12);

    nx_halt = 1'b1; run(5);
    nx_halt = 1'b0; run(10);

    for (int i = 0; i < 800; i++) begin
      logic [31:0] r;
      r = $urandom;
      nx_ready = (r[1:0] != 2'b00);
      nx_halt  = (r[4:2] == 3'b000);
      nx_flush = (r[9:5] == 5'b00000);
      nx_rst   = (r[16:10] == 7'd0);
      nx_redirect = r[31] ? (32'hFFFF_FFF0 | {28'h0, r[30:29], 2'b00}) : ({$urandom} & 32'hFFFF_FFFC);
      step();
    end
    nx_rst = 1'b0; nx_flush = 1'b0; nx_halt = 1'b0; nx_ready = 1'b1;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
